// File: rtl/imem_fill.sv
// L1 I-cache line-fill engine: issues BEATS pipelined bus reads for one line,
// assembles the beats little-endian and returns the line with a one-cycle valid pulse.
module imem_fill #(
  parameter int LINE_W  = 256,
  parameter int BUS_W   = 64,
  parameter int BLK_LEN = 59
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLK_LEN-1:0] b_addr_i,
  input  logic               b_rd_i,
  output logic [LINE_W-1:0]  b_data_i,
  output logic               b_dv_i,
  output logic               fill_err,
  output logic [63:0]        m_ar_addr,
  output logic               m_ar_valid,
  input  logic               m_ar_ready,
  input  logic [BUS_W-1:0]   m_r_data,
  input  logic               m_r_err,
  input  logic               m_r_valid
);

  localparam int BEATS      = LINE_W / BUS_W;
  localparam int CNT_W      = $clog2(BEATS) + 1;
  localparam int OFF_W      = 64 - BLK_LEN;
  localparam int BEAT_BYTES = BUS_W / 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [BLK_LEN-1:0] line_addr_q, line_addr_d;
  logic [CNT_W-1:0]   a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0]   d_cnt_q, d_cnt_d;
  logic               err_acc_q, err_acc_d;
  logic [LINE_W-1:0]  line_buf_q, line_buf_d;
  logic [LINE_W-1:0]  b_data_q, b_data_d;
  logic               b_dv_q, b_dv_d;
  logic               fill_err_q, fill_err_d;
  logic [63:0]        m_ar_addr_q, m_ar_addr_d;
  logic               m_ar_valid_q, m_ar_valid_d;

  logic               capture;
  logic               last_beat;
  logic               ar_fire;
  logic [BEATS-1:0]   lane_we;
  logic [63:0]        line_base;

  // Beats are only taken while a fill is in flight; anything else is a stray response.
  assign capture   = m_r_valid && ((state_q == S_REQ) || (state_q == S_WAIT))
                     && (d_cnt_q != CNT_FULL);
  assign last_beat = capture && (d_cnt_q == LAST_BEAT);
  assign ar_fire   = m_ar_valid_q && m_ar_ready;
  assign line_base = {line_addr_q, {OFF_W{1'b0}}};

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
    assign lane_we[gi] = capture && (d_cnt_q == CNT_W'(gi));
    assign line_buf_d[gi*BUS_W +: BUS_W] = lane_we[gi] ? m_r_data
                                                       : line_buf_q[gi*BUS_W +: BUS_W];
  end

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    a_cnt_d      = a_cnt_q;
    d_cnt_d      = capture ? d_cnt_q + CNT_W'(1) : d_cnt_q;
    err_acc_d    = err_acc_q | (capture & m_r_err);
    b_data_d     = b_data_q;
    b_dv_d       = 1'b0;
    fill_err_d   = 1'b0;
    m_ar_addr_d  = m_ar_addr_q;
    m_ar_valid_d = m_ar_valid_q;

    case (state_q)
      S_IDLE: begin
        if (b_rd_i) state_d = S_ARM;
      end
      S_ARM: begin
        line_addr_d  = b_addr_i;
        a_cnt_d      = '0;
        d_cnt_d      = '0;
        err_acc_d    = 1'b0;
        m_ar_valid_d = 1'b1;
        m_ar_addr_d  = {b_addr_i, {OFF_W{1'b0}}};
        state_d      = S_REQ;
      end
      S_REQ: begin
        if (ar_fire) begin
          a_cnt_d = a_cnt_q + CNT_W'(1);
          if (a_cnt_q == LAST_BEAT) begin
            m_ar_valid_d = 1'b0;
            state_d      = last_beat ? S_DONE : S_WAIT;
          end else begin
            m_ar_addr_d = line_base + (64'(a_cnt_d) * 64'(BEAT_BYTES));
          end
        end
      end
      S_WAIT: begin
        if (last_beat) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = b_rd_i ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!b_rd_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Snapshot the line including the beat landing this cycle.
    if (state_d == S_DONE) begin
      b_dv_d     = 1'b1;
      fill_err_d = err_acc_d;
      b_data_d   = line_buf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      line_addr_q  <= '0;
      a_cnt_q      <= '0;
      d_cnt_q      <= '0;
      err_acc_q    <= 1'b0;
      line_buf_q   <= '0;
      b_data_q     <= '0;
      b_dv_q       <= 1'b0;
      fill_err_q   <= 1'b0;
      m_ar_addr_q  <= '0;
      m_ar_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      a_cnt_q      <= a_cnt_d;
      d_cnt_q      <= d_cnt_d;
      err_acc_q    <= err_acc_d;
      line_buf_q   <= line_buf_d;
      b_data_q     <= b_data_d;
      b_dv_q       <= b_dv_d;
      fill_err_q   <= fill_err_d;
      m_ar_addr_q  <= m_ar_addr_d;
      m_ar_valid_q <= m_ar_valid_d;
    end
  end

  assign b_data_i   = b_data_q;
  assign b_dv_i     = b_dv_q;
  assign fill_err   = fill_err_q;
  assign m_ar_addr  = m_ar_addr_q;
  assign m_ar_valid = m_ar_valid_q;

endmodule

// File: doc/imem_fill.md
Name: imem_fill

Overview:
- L1 instruction-cache line-fill engine, directly downstream of the L1 I-cache miss port.
- Accepts one line request at a time over the b_rd_i / b_addr_i / b_dv_i interface and reads the line as BEATS sequential bus-width beats over a pipelined read bus.
- Assembles the beats into one LINE_W-bit line and returns it with a single-cycle data-valid pulse.
- Up to BEATS address beats may be outstanding; responses return in order.

Parameters:
- LINE_W, 256, cache line width in bits (matches `IMEM_LINE).
- BUS_W, 64, system read-data width in bits; LINE_W must be a power-of-two multiple of BUS_W, giving BEATS = LINE_W/BUS_W.
- BLK_LEN, 59, line address width (matches `IMEM_BLK_LEN); must equal 64 - log2(LINE_W/8).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- b_addr_i  in  BLK_LEN  line address from the cache
- b_rd_i  in  1  line request, held high until data is returned
- b_data_i  out  LINE_W  assembled line
- b_dv_i  out  1  one-cycle line-valid pulse
- fill_err  out  1  pulses together with b_dv_i if any beat returned an error
- m_ar_addr  out  64  byte address of the current beat
- m_ar_valid  out  1  address request valid
- m_ar_ready  in  1  address accepted
- m_r_data  in  BUS_W  beat read data
- m_r_err  in  1  beat error, qualified by m_r_valid
- m_r_valid  in  1  beat data valid; the block is always ready to accept it

Behaviour:
- Reset is asynchronous on rst_n low. State becomes S_IDLE; m_ar_valid, b_dv_i, fill_err and all counters are 0; b_data_i is 0.
- Handshake timing on the cache side: b_addr_i is valid from the cycle after b_rd_i rises, because the cache registers it.
- S_IDLE: when b_rd_i = 1, go to S_ARM. Any m_r_valid seen here is dropped; this covers stray beats after a reset.
- S_ARM (1 cycle):
  - latch line_addr <= b_addr_i;
  - clear a_cnt, d_cnt and err_acc;
  - go to S_REQ.
- S_REQ:
  - drive m_ar_valid = 1 and m_ar_addr = {line_addr, 0s} + a_cnt*(BUS_W/8);
  - on m_ar_valid && m_ar_ready, increment a_cnt;
  - when the beat with a_cnt = BEATS-1 is accepted, go to S_WAIT with m_ar_valid dropped next cycle.
- Data capture (in S_REQ and S_WAIT):
  - on m_r_valid, write line_buf[d_cnt*BUS_W +: BUS_W] <= m_r_data, increment d_cnt, and OR m_r_err into err_acc;
  - beat 0 occupies the least-significant bits (little-endian);
  - data may arrive in the same cycle its address is accepted, or later.
- S_WAIT: when the beat with d_cnt = BEATS-1 is captured, go to S_DONE. If the last beat arrives while still in S_REQ after all addresses were accepted, go to S_DONE directly.
- S_DONE (1 cycle):
  - b_dv_i = 1;
  - b_data_i = line_buf, held stable until the next fill completes;
  - fill_err = err_acc;
  - go to S_HOLD.
- S_HOLD:
  - go to S_IDLE once b_rd_i = 0;
  - if b_rd_i is already 0, the transition happens in the same cycle;
  - this prevents re-triggering on the cycle after b_dv_i while the cache leaves its fetch state.
- Counters a_cnt and d_cnt are log2(BEATS)+1 bits wide. d_cnt never exceeds a_cnt, because a response implies an accepted address. A beat arriving with d_cnt = BEATS is a protocol violation; the bench asserts it never happens.
- Latency:
  - with m_ar_ready tied high and response latency L, b_dv_i rises 2 + BEATS + L cycles after b_rd_i rises;
  - minimum with BEATS = 4 and L = 0 is 6 cycles.
- b_rd_i deasserting mid-fill does not abort the fill; the fill completes and b_dv_i still pulses.
- Reset mid-fill abandons the fill immediately. Late beats arriving after reset are discarded in S_IDLE.

Test Plan:
- Basic fill:
  - stimulus: b_addr_i = 0x0000_0000_0000_040 (line 0x40); m_ar_ready = 1; m_r_valid same cycle as acceptance; data 0x11..11, 0x22..22, 0x33..33, 0x44..44;
  - required: m_ar_addr sequence 0x800, 0x808, 0x810, 0x818; b_dv_i one cycle at cycle 6; b_data_i = {0x44..,0x33..,0x22..,0x11..}; fill_err = 0.
- Backpressure:
  - stimulus: m_ar_ready low for 3 cycles on beat 2;
  - required: m_ar_addr holds 0x810 with m_ar_valid = 1 throughout the stall; line is correct; b_dv_i is delayed by 3 cycles.
- Latent responses:
  - stimulus: all 4 addresses accepted back-to-back; responses arrive 5 cycles later with 1-cycle gaps;
  - required: correct assembly; no lost beat; b_dv_i exactly once.
- Error beat:
  - stimulus: m_r_err = 1 on beat 1 only;
  - required: fill_err = 1 coincident with b_dv_i; fill_err = 0 on the next clean fill.
- Hold / no re-trigger:
  - stimulus: b_rd_i stays high 2 cycles after b_dv_i;
  - required: no second S_ARM; m_ar_valid stays 0 until b_rd_i has gone low and then high again.
- Reset mid-fill:
  - stimulus: assert rst_n = 0 after 2 beats accepted, release, then deliver 2 stale m_r_valid beats and start a new request to line 0x41;
  - required: stale beats ignored; new fill returns line 0x41's data; addresses start at 0x820.
